core_mem_bridge: RTL and testbench

- Per-port bridge between one SCR1 memory interface (IMEM or DMEM) and the node's local RAM slice plus the NoC request/response path.
- Decodes each core request by address region. Local hits are served from the RAM port. Remote requests are tagged with a rolling packet ID, sent to the splitter side, and matched against collector responses, with a timeout.
- Instantiated once per core port (IMEM, DMEM) inside the node's core router. It is the parametrised successor of the single-port DMEM-only routing logic.

---
 rtl/core_mem_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_core_mem_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_bridge.sv
// Per-port bridge from an SCR1 memory port to the local RAM slice and the NoC request/response path.
// Decodes by node region, tags remote requests with a rolling packet id and times out lost responses.
module core_mem_bridge #(
  parameter int unsigned NODE_ID         = 0,
  parameter int unsigned NODE_COUNT      = 9,
  parameter int unsigned AWIDTH          = 32,
  parameter int unsigned DWIDTH          = 32,
  parameter int unsigned REGION_BYTES    = 4096,
  parameter int unsigned PACKET_ID_WIDTH = 5,
  parameter int unsigned TIMEOUT         = 1023,
  parameter int unsigned READ_ONLY       = 0,
  localparam int unsigned NODE_W         = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1,
  localparam int unsigned BE_W           = DWIDTH / 8,
  localparam int unsigned OFF_W          = $clog2(REGION_BYTES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       core_req_i,
  input  logic                       core_cmd_i,
  input  logic [1:0]                 core_width_i,
  input  logic [AWIDTH-1:0]          core_addr_i,
  input  logic [DWIDTH-1:0]          core_wdata_i,
  output logic                       core_req_ack_o,
  output logic [DWIDTH-1:0]          core_rdata_o,
  output logic [1:0]                 core_resp_o,
  output logic                       ram_en_o,
  output logic                       ram_we_o,
  output logic [BE_W-1:0]            ram_be_o,
  output logic [OFF_W-3:0]           ram_addr_o,
  output logic [DWIDTH-1:0]          ram_wdata_o,
  input  logic [DWIDTH-1:0]          ram_rdata_i,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  output logic [NODE_W-1:0]          tx_dest_o,
  output logic                       tx_cmd_o,
  output logic [BE_W-1:0]            tx_be_o,
  output logic [AWIDTH-1:0]          tx_addr_o,
  output logic [DWIDTH-1:0]          tx_wdata_o,
  output logic [PACKET_ID_WIDTH-1:0] tx_pid_o,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o,
  input  logic [PACKET_ID_WIDTH-1:0] rx_pid_i,
  input  logic                       rx_err_i,
  input  logic [DWIDTH-1:0]          rx_rdata_i
);

  localparam int unsigned REG_W = AWIDTH - OFF_W;
  localparam int unsigned PID_W = PACKET_ID_WIDTH;
  localparam int unsigned TMO_W = 32;

  localparam logic [1:0] RESP_NOTRDY = 2'b00;
  localparam logic [1:0] RESP_OK     = 2'b01;
  localparam logic [1:0] RESP_ER     = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCAL,
    S_REMOTE_TX,
    S_REMOTE_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic                r_cmd;
  logic [BE_W-1:0]     r_be;
  logic [AWIDTH-1:0]   r_addr;
  logic [DWIDTH-1:0]   r_wdata;
  logic [NODE_W-1:0]   r_dest;
  logic                r_err;
  logic [DWIDTH-1:0]   r_rdata;
  logic [PID_W-1:0]    r_pid;
  logic [PID_W-1:0]    r_cur_pid;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_rx_ready;

  logic [REG_W-1:0]    w_region;
  logic                w_local;
  logic                w_unmapped;
  logic                w_misalign;
  logic                w_ro_wr;
  logic                w_bad;
  logic [BE_W-1:0]     w_be;
  logic                w_match;
  logic                w_tmo;

  // Address region decode and lane/alignment checks
  assign w_region   = core_addr_i[AWIDTH-1:OFF_W];
  assign w_local    = (w_region == REG_W'(NODE_ID));
  assign w_unmapped = (w_region >= REG_W'(NODE_COUNT));
  assign w_ro_wr    = (READ_ONLY != 0) && core_cmd_i;
  assign w_bad      = w_misalign || w_unmapped || w_ro_wr;

  always_comb begin
    w_be       = '0;
    w_misalign = 1'b0;
    case (core_width_i)
      2'b00: w_be = BE_W'(1) << core_addr_i[1:0];
      2'b01: begin
        w_be       = BE_W'(3) << core_addr_i[1:0];
        w_misalign = core_addr_i[0];
      end
      2'b10: begin
        w_be       = '1;
        w_misalign = |core_addr_i[1:0];
      end
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_match = rx_valid_i && (rx_pid_i == r_cur_pid);
  assign w_tmo   = (TIMEOUT != 0) && (r_tmo == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    core_req_ack_o = 1'b0;
    core_rdata_o   = '0;
    core_resp_o    = RESP_NOTRDY;
    ram_en_o       = 1'b0;
    ram_we_o       = 1'b0;
    ram_be_o       = '0;
    ram_addr_o     = '0;
    ram_wdata_o    = '0;
    tx_valid_o     = 1'b0;
    tx_dest_o      = '0;
    tx_cmd_o       = 1'b0;
    tx_be_o        = '0;
    tx_addr_o      = '0;
    tx_wdata_o     = '0;
    tx_pid_o       = '0;
    case (r_state)
      S_IDLE: begin
        if (core_req_i) begin
          core_req_ack_o = 1'b1;
          if (w_bad) begin
            w_next = S_RESP;
          end else if (w_local) begin
            ram_en_o    = 1'b1;
            ram_we_o    = core_cmd_i;
            ram_be_o    = w_be;
            ram_addr_o  = core_addr_i[OFF_W-1:2];
            ram_wdata_o = core_wdata_i;
            w_next      = S_LOCAL;
          end else begin
            w_next = S_REMOTE_TX;
          end
        end
      end
      S_LOCAL: begin
        core_resp_o  = RESP_OK;
        core_rdata_o = ram_rdata_i;
        w_next       = S_IDLE;
      end
      S_REMOTE_TX: begin
        tx_valid_o = 1'b1;
        tx_dest_o  = r_dest;
        tx_cmd_o   = r_cmd;
        tx_be_o    = r_be;
        tx_addr_o  = r_addr;
        tx_wdata_o = r_wdata;
        tx_pid_o   = r_pid;
        if (tx_ready_i) w_next = S_REMOTE_WAIT;
      end
      S_REMOTE_WAIT: begin
        if (w_match || w_tmo) w_next = S_RESP;
      end
      S_RESP: begin
        core_resp_o  = r_err ? RESP_ER : RESP_OK;
        core_rdata_o = r_rdata;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture, pid rolling, response capture and timeout counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dest     <= '0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
      r_pid      <= '0;
      r_cur_pid  <= '0;
      r_tmo      <= '0;
      r_rx_ready <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (core_req_i) begin
            r_cmd   <= core_cmd_i;
            r_be    <= w_be;
            r_addr  <= core_addr_i;
            r_wdata <= core_wdata_i;
            r_dest  <= NODE_W'(w_region);
            r_err   <= w_bad;
            r_rdata <= '0;
          end
        end
        S_LOCAL: r_rdata <= ram_rdata_i;
        S_REMOTE_TX: begin
          if (tx_ready_i) begin
            r_cur_pid <= r_pid;
            r_pid     <= r_pid + PID_W'(1);
            r_tmo     <= '0;
          end
        end
        S_REMOTE_WAIT: begin
          r_tmo <= r_tmo + TMO_W'(1);
          if (w_match) begin
            r_rdata <= rx_rdata_i;
            r_err   <= rx_err_i;
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready_o = r_rx_ready;

endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed bench for core_mem_bridge: local, remote, stale-pid, pid wrap, error, timeout and reset cases.
module tb_core_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_req, core_cmd;
  logic [1:0]  core_width;
  logic [31:0] core_addr, core_wdata, ram_rdata;
  logic        tx_ready, rx_valid, rx_err;
  logic [4:0]  rx_pid;
  logic [31:0] rx_rdata;

  logic        ack, ram_en, ram_we, tx_valid, tx_cmd, rx_ready;
  logic [31:0] rdata, ram_wdata, tx_addr, tx_wdata;
  logic [1:0]  resp;
  logic [3:0]  ram_be, tx_be, tx_dest;
  logic [9:0]  ram_addr;
  logic [4:0]  tx_pid;

  logic        ro_ack, ro_ram_en, ro_ram_we, ro_tx_valid, ro_tx_cmd, ro_rx_ready;
  logic [31:0] ro_rdata, ro_ram_wdata, ro_tx_addr, ro_tx_wdata;
  logic [1:0]  ro_resp;
  logic [3:0]  ro_ram_be, ro_tx_be, ro_tx_dest;
  logic [9:0]  ro_ram_addr;
  logic [4:0]  ro_tx_pid;

  int n_checks = 0;
  int n_errors = 0;
  int exp_pid  = 0;

  always #5 clk = ~clk;

  core_mem_bridge #(.NODE_ID(1), .NODE_COUNT(9), .TIMEOUT(10), .READ_ONLY(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_cmd_i(core_cmd), .core_width_i(core_width),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_req_ack_o(ack), .core_rdata_o(rdata), .core_resp_o(resp),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .tx_valid_o(tx_valid), .tx_ready_i(tx_ready), .tx_dest_o(tx_dest), .tx_cmd_o(tx_cmd),
    .tx_be_o(tx_be), .tx_addr_o(tx_addr), .tx_wdata_o(tx_wdata), .tx_pid_o(tx_pid),
    .rx_valid_i(rx_valid), .rx_ready_o(rx_ready), .rx_pid_i(rx_pid), .rx_err_i(rx_err),
    .rx_rdata_i(rx_rdata)
  );

  core_mem_bridge #(.NODE_ID(1), .NODE_COUNT(9), .TIMEOUT(10), .READ_ONLY(1)) u_ro (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req), .core_cmd_i(core_cmd), .core_width_i(core_width),
    .core_addr_i(core_addr), .core_wdata_i(core_wdata),
    .core_req_ack_o(ro_ack), .core_rdata_o(ro_rdata), .core_resp_o(ro_resp),
    .ram_en_o(ro_ram_en), .ram_we_o(ro_ram_we), .ram_be_o(ro_ram_be), .ram_addr_o(ro_ram_addr),
    .ram_wdata_o(ro_ram_wdata), .ram_rdata_i(ram_rdata),
    .tx_valid_o(ro_tx_valid), .tx_ready_i(tx_ready), .tx_dest_o(ro_tx_dest), .tx_cmd_o(ro_tx_cmd),
    .tx_be_o(ro_tx_be), .tx_addr_o(ro_tx_addr), .tx_wdata_o(ro_tx_wdata), .tx_pid_o(ro_tx_pid),
    .rx_valid_i(rx_valid), .rx_ready_o(ro_rx_ready), .rx_pid_i(rx_pid), .rx_err_i(rx_err),
    .rx_rdata_i(rx_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
    core_req   = 1'b1;
    core_cmd   = cmd;
    core_width = w;
    core_addr  = a;
    core_wdata = d;
    #1;
  endtask

  // Full remote read with immediate splitter accept and a matching response
  task automatic remote_rd(input logic [31:0] a, input logic [31:0] d);
    issue(1'b0, 2'b10, a, 32'h0);
    chk("rr_ack", 32'(ack), 32'd1);
    cyc();
    core_req = 1'b0;
    #1;
    chk("rr_txv", 32'(tx_valid), 32'd1);
    chk("rr_pid", 32'(tx_pid), 32'(exp_pid % 32));
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    rx_valid = 1'b1;
    rx_pid   = 5'(exp_pid % 32);
    rx_rdata = d;
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("rr_resp", 32'(resp), 32'd1);
    chk("rr_rdata", rdata, d);
    exp_pid++;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; core_req = 1'b0; core_cmd = 1'b0; core_width = 2'b00;
    core_addr = '0; core_wdata = '0; ram_rdata = '0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_err = 1'b0; rx_pid = '0; rx_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_rx_ready", 32'(rx_ready), 32'd1);

    // Local word read
    issue(1'b0, 2'b10, 32'h0000_1008, 32'h0);
    ram_rdata = 32'h1234_5678;
    #1;
    chk("lw_ack", 32'(ack), 32'd1);
    chk("lw_ram_en", 32'(ram_en), 32'd1);
    chk("lw_ram_addr", 32'(ram_addr), 32'd2);
    chk("lw_ram_we", 32'(ram_we), 32'd0);
    chk("lw_ram_be", 32'(ram_be), 32'hF);
    chk("lw_tx_valid", 32'(tx_valid), 32'd0);
    cyc();
    core_req = 1'b0;
    #1;
    chk("lw_resp", 32'(resp), 32'd1);
    chk("lw_rdata", rdata, 32'h1234_5678);
    chk("lw_ack_busy", 32'(ack), 32'd0);
    cyc();
    chk("lw_resp_done", 32'(resp), 32'd0);

    // Local byte store to lane 3
    issue(1'b1, 2'b00, 32'h0000_1003, 32'hAB00_0000);
    chk("sb_ram_be", 32'(ram_be), 32'h8);
    chk("sb_ram_we", 32'(ram_we), 32'd1);
    chk("sb_ram_wdata", ram_wdata, 32'hAB00_0000);
    chk("sb_ram_addr", 32'(ram_addr), 32'd0);
    cyc();
    core_req = 1'b0;
    #1;
    chk("sb_resp", 32'(resp), 32'd1);
    cyc();

    // Remote read with splitter stalled for three cycles
    issue(1'b0, 2'b10, 32'h0000_3010, 32'h0);
    chk("rw_ack", 32'(ack), 32'd1);
    chk("rw_ram_en", 32'(ram_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      core_req = 1'b0;
      #1;
      chk("rw_stall_txv", 32'(tx_valid), 32'd1);
      chk("rw_stall_dest", 32'(tx_dest), 32'd3);
      chk("rw_stall_pid", 32'(tx_pid), 32'd0);
      chk("rw_stall_addr", tx_addr, 32'h0000_3010);
    end
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    chk("rw_wait_txv", 32'(tx_valid), 32'd0);
    chk("rw_wait_rx_ready", 32'(rx_ready), 32'd1);
    rx_valid = 1'b1; rx_pid = 5'd0; rx_rdata = 32'hDEAD_BEEF;
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("rw_resp", 32'(resp), 32'd1);
    chk("rw_rdata", rdata, 32'hDEAD_BEEF);
    cyc();
    exp_pid = 1;

    // Stale pid 7 dropped, matching pid 1 completes
    issue(1'b0, 2'b10, 32'h0000_2000, 32'h0);
    cyc();
    core_req = 1'b0;
    #1;
    chk("st_pid", 32'(tx_pid), 32'd1);
    chk("st_dest", 32'(tx_dest), 32'd2);
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    rx_valid = 1'b1; rx_pid = 5'd7; rx_rdata = 32'h1111_1111;
    cyc();
    chk("st_stale_resp", 32'(resp), 32'd0);
    rx_pid = 5'd1; rx_rdata = 32'hCAFE_F00D;
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("st_resp", 32'(resp), 32'd1);
    chk("st_rdata", rdata, 32'hCAFE_F00D);
    cyc();
    exp_pid = 2;

    // 33 remote reads, pid walks 2..31 then wraps through 0
    for (int i = 0; i < 33; i++) remote_rd(32'h0000_2000 + 32'(i * 4), 32'hA500_0000 | 32'(i));
    chk("wrap_count", 32'(exp_pid % 32), 32'd3);

    // Misaligned halfword and unmapped region
    issue(1'b0, 2'b01, 32'h0000_1001, 32'h0);
    chk("lh_ack", 32'(ack), 32'd1);
    chk("lh_ram_en", 32'(ram_en), 32'd0);
    cyc();
    core_req = 1'b0;
    #1;
    chk("lh_resp", 32'(resp), 32'd2);
    chk("lh_tx_valid", 32'(tx_valid), 32'd0);
    cyc();
    issue(1'b0, 2'b10, 32'h0000_9000, 32'h0);
    chk("um_ack", 32'(ack), 32'd1);
    chk("um_ram_en", 32'(ram_en), 32'd0);
    cyc();
    core_req = 1'b0;
    #1;
    chk("um_resp", 32'(resp), 32'd2);
    chk("um_tx_valid", 32'(tx_valid), 32'd0);
    chk("um_ram_en2", 32'(ram_en), 32'd0);
    cyc();

    // Timeout: no response, RDY_ER ten edges after the handshake
    issue(1'b0, 2'b10, 32'h0000_4000, 32'h0);
    cyc();
    core_req = 1'b0;
    #1;
    chk("to_pid", 32'(tx_pid), 32'(exp_pid % 32));
    tx_ready = 1'b1;
    cyc();
    tx_ready = 1'b0;
    for (int k = 1; k < 10; k++) begin
      cyc();
      chk("to_wait_resp", 32'(resp), 32'd0);
    end
    cyc();
    chk("to_resp", 32'(resp), 32'd2);
    cyc();
    chk("to_idle_resp", 32'(resp), 32'd0);
    rx_valid = 1'b1; rx_pid = 5'(exp_pid % 32); rx_rdata = 32'h5555_5555;
    #1;
    chk("to_late_rx_ready", 32'(rx_ready), 32'd1);
    cyc();
    rx_valid = 1'b0;
    #1;
    chk("to_late_resp", 32'(resp), 32'd0);
    exp_pid++;

    // Read-only port rejects a store, normal port accepts it
    issue(1'b1, 2'b10, 32'h0000_1000, 32'h55AA_55AA);
    chk("ro_ack", 32'(ro_ack), 32'd1);
    chk("ro_ram_en", 32'(ro_ram_en), 32'd0);
    chk("ro_main_ram_en", 32'(ram_en), 32'd1);
    cyc();
    core_req = 1'b0;
    #1;
    chk("ro_resp", 32'(ro_resp), 32'd2);
    chk("ro_main_resp", 32'(resp), 32'd1);
    chk("ro_tx_valid", 32'(ro_tx_valid), 32'd0);
    cyc();

    // Reset during REMOTE_TX aborts and clears pid
    issue(1'b0, 2'b10, 32'h0000_5000, 32'h0);
    cyc();
    core_req = 1'b0;
    #1;
    chk("ra_txv", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ra_txv_rst", 32'(tx_valid), 32'd0);
    chk("ra_pid_rst", 32'(tx_pid), 32'd0);
    chk("ra_addr_rst", tx_addr, 32'h0);
    chk("ra_dest_rst", 32'(tx_dest), 32'd0);
    chk("ra_rx_ready_rst", 32'(rx_ready), 32'd0);
    chk("ra_resp_rst", 32'(resp), 32'd0);
    cyc();
    rst_n = 1'b1;
    exp_pid = 0;
    cyc();
    remote_rd(32'h0000_3000, 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
